key_rotary_conditioner: RTL and testbench

//  Input-side front end for the board's user controls: the active-low push keys and the 4-bit active-low rotary switch.

---
 rtl/key_rotary_conditioner.sv | 206 ++++++++++++++++++++
 tb/tb_key_rotary_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_rotary_conditioner.sv
// key_rotary_conditioner
//   Front end for the board's user controls. Synchronises the active-low push
//   keys and the active-low 4-bit rotary switch, debounces them and turns them
//   into clean active-high levels plus single-cycle event pulses, so that
//   downstream counter/display logic never needs its own edge detection.
//
//   Ports
//     i_clk          system clock
//     i_rstn         asynchronous reset, active low
//     i_key          raw keys, active low (0 = pressed)
//     i_rotary       raw rotary code, active low
//     o_key_level    debounced key state, 1 = pressed
//     o_key_press    1-cycle pulse on accepted press
//     o_key_release  1-cycle pulse on accepted release
//     o_key_long     1-cycle pulse, once per press, after LONG_CYC pressed cycles
//     o_rotary       debounced rotary value, active high
//     o_rotary_chg   1-cycle pulse when o_rotary takes a new value
//
//   Key FSM
//     state     | meaning
//     K_IDLE    | key released and stable
//     K_PRESS_CHK | key seen pressed, counting consecutive pressed cycles
//     K_PRESSED | press accepted, long-press counter running
//     K_REL_CHK | key seen released, counting consecutive released cycles
module key_rotary_conditioner #(
    parameter int NUM_KEYS = 2,
    parameter int DEB_CYC  = 500000,
    parameter int LONG_CYC = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NUM_KEYS-1:0] i_key,
    input  logic [3:0]          i_rotary,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_long,
    output logic [3:0]          o_rotary,
    output logic                o_rotary_chg
);

    // The check counter holds (cycles seen - 1): the first qualifying cycle is
    // the one that enters the check state and clears the counter.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_TC    = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);

    typedef enum logic [1:0] {
        K_IDLE      = 2'd0,
        K_PRESS_CHK = 2'd1,
        K_PRESSED   = 2'd2,
        K_REL_CHK   = 2'd3
    } key_state_t;

    // Two-flop synchronisers; they clear to the pin's released / rotary-0 value.
    logic [NUM_KEYS-1:0] key_meta;
    logic [NUM_KEYS-1:0] key_sync;
    logic [3:0]          rot_meta;
    logic [3:0]          rot_sync;
    logic [NUM_KEYS-1:0] s_key;
    logic [3:0]          s_rot;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            key_meta <= '1;
            key_sync <= '1;
            rot_meta <= 4'hF;
            rot_sync <= 4'hF;
        end else begin
            key_meta <= i_key;
            key_sync <= key_meta;
            rot_meta <= i_rotary;
            rot_sync <= rot_meta;
        end
    end

    assign s_key = ~key_sync;
    assign s_rot = ~rot_sync;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_state_t       state;
        logic [CNT_W-1:0] deb_cnt;
        logic [CNT_W-1:0] deb_nxt;
        logic [CNT_W-1:0] long_cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;

        assign deb_nxt = deb_cnt + CNT_ONE;

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                state     <= K_IDLE;
                deb_cnt   <= '0;
                long_cnt  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state)
                    K_IDLE: begin
                        level_q <= 1'b0;
                        if (s_key[g]) begin
                            state   <= K_PRESS_CHK;
                            deb_cnt <= '0;
                        end
                    end
                    K_PRESS_CHK: begin
                        if (!s_key[g]) begin
                            state <= K_IDLE;
                        end else if (deb_nxt == DEB_TC) begin
                            state    <= K_PRESSED;
                            level_q  <= 1'b1;
                            press_q  <= 1'b1;
                            long_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_nxt;
                        end
                    end
                    K_PRESSED: begin
                        // Saturating count: the pulse fires on the single
                        // LONG_CYC-1 -> LONG_CYC step, so it never repeats.
                        if (long_cnt != LONG_MAX) begin
                            long_cnt <= long_cnt + CNT_ONE;
                        end
                        if (long_cnt == LONG_LAST) begin
                            long_q <= 1'b1;
                        end
                        if (!s_key[g]) begin
                            state   <= K_REL_CHK;
                            deb_cnt <= '0;
                        end
                    end
                    K_REL_CHK: begin
                        // long_cnt is frozen here so a bounce does not restart it.
                        if (s_key[g]) begin
                            state <= K_PRESSED;
                        end else if (deb_nxt == DEB_TC) begin
                            state     <= K_IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            deb_cnt <= deb_nxt;
                        end
                    end
                    default: begin
                        state <= K_IDLE;
                    end
                endcase
            end
        end

        assign o_key_level[g]   = level_q;
        assign o_key_press[g]   = press_q;
        assign o_key_release[g] = release_q;
        assign o_key_long[g]    = long_q;
    end

    // Rotary filter: a new code must be held unchanged for DEB_CYC cycles.
    logic [3:0]       rot_q;
    logic [3:0]       rot_cand;
    logic             rot_busy;
    logic             rot_chg_q;
    logic [CNT_W-1:0] rot_cnt;
    logic [CNT_W-1:0] rot_nxt;

    assign rot_nxt = rot_cnt + CNT_ONE;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rot_q     <= 4'h0;
            rot_cand  <= 4'h0;
            rot_busy  <= 1'b0;
            rot_chg_q <= 1'b0;
            rot_cnt   <= '0;
        end else begin
            rot_chg_q <= 1'b0;
            if (s_rot == rot_q) begin
                rot_busy <= 1'b0;
                rot_cnt  <= '0;
            end else if (!rot_busy || (s_rot != rot_cand)) begin
                rot_cand <= s_rot;
                rot_busy <= 1'b1;
                rot_cnt  <= '0;
            end else if (rot_nxt == DEB_TC) begin
                rot_q     <= rot_cand;
                rot_chg_q <= 1'b1;
                rot_busy  <= 1'b0;
                rot_cnt   <= '0;
            end else begin
                rot_cnt <= rot_nxt;
            end
        end
    end

    assign o_rotary     = rot_q;
    assign o_rotary_chg = rot_chg_q;

endmodule

// File: tb/tb_key_rotary_conditioner.sv
module tb_key_rotary_conditioner;

    localparam int NK    = 2;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int CNT_W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NK-1:0] i_key = 2'b11;
    logic [3:0]    i_rotary = 4'hF;
    logic [NK-1:0] o_key_level, o_key_press, o_key_release, o_key_long;
    logic [3:0]    o_rotary;
    logic          o_rotary_chg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    key_rotary_conditioner #(
        .NUM_KEYS(NK), .DEB_CYC(DEB), .LONG_CYC(LONG), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_key(i_key), .i_rotary(i_rotary),
        .o_key_level(o_key_level), .o_key_press(o_key_press),
        .o_key_release(o_key_release), .o_key_long(o_key_long),
        .o_rotary(o_rotary), .o_rotary_chg(o_rotary_chg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural model: a debounced value follows the synchronised input once
    // that input has held one value, different from the current debounced value,
    // for DEB consecutive cycles. Long press counts cycles the key is accepted
    // as pressed and the previous sample was also pressed.
    logic [NK-1:0] pd1 = '1, pd2 = '1;
    logic [3:0]    rd1 = 4'hF, rd2 = 4'hF;
    logic [NK-1:0] ks;
    logic [3:0]    rs;
    int            k_run [NK];
    logic          k_prev[NK];
    logic          k_lvl [NK];
    int            k_hold[NK];
    int            r_run = 0;
    logic [3:0]    r_prev = 4'h0;
    logic [3:0]    r_val  = 4'h0;
    logic [NK-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0;
    logic [3:0]    e_rot = 4'h0;
    logic          e_chg = 1'b0;

    initial begin
        for (int i = 0; i < NK; i++) begin
            k_run[i] = 0; k_prev[i] = 1'b0; k_lvl[i] = 1'b0; k_hold[i] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd1 = '1; pd2 = '1; rd1 = 4'hF; rd2 = 4'hF;
            for (int i = 0; i < NK; i++) begin
                k_run[i] = 0; k_prev[i] = 1'b0; k_lvl[i] = 1'b0; k_hold[i] = 0;
            end
            r_run = 0; r_prev = 4'h0; r_val = 4'h0;
            e_level = '0; e_press = '0; e_rel = '0; e_long = '0;
            e_rot = 4'h0; e_chg = 1'b0;
        end else begin
            ks = ~pd2;
            rs = ~rd2;
            pd2 = pd1; pd1 = i_key;
            rd2 = rd1; rd1 = i_rotary;
            e_press = '0; e_rel = '0; e_long = '0; e_chg = 1'b0;
            for (int i = 0; i < NK; i++) begin
                if (k_lvl[i] && k_prev[i] && k_hold[i] < LONG) begin
                    k_hold[i]++;
                    if (k_hold[i] == LONG) e_long[i] = 1'b1;
                end
                if (ks[i] == k_prev[i]) k_run[i]++;
                else k_run[i] = 1;
                k_prev[i] = ks[i];
                if (ks[i] != k_lvl[i] && k_run[i] == DEB) begin
                    k_lvl[i] = ks[i];
                    if (ks[i]) begin
                        e_press[i] = 1'b1;
                        k_hold[i]  = 0;
                    end else begin
                        e_rel[i] = 1'b1;
                    end
                end
                e_level[i] = k_lvl[i];
            end
            if (rs == r_prev) r_run++;
            else r_run = 1;
            r_prev = rs;
            if (rs != r_val && r_run == DEB) begin
                r_val = rs;
                e_chg = 1'b1;
            end
            e_rot = r_val;
        end
    end

    always @(negedge clk) begin
        check("level",   o_key_level,   e_level);
        check("press",   o_key_press,   e_press);
        check("release", o_key_release, e_rel);
        check("long",    o_key_long,    e_long);
        check("rotary",  o_rotary,      e_rot);
        check("rot_chg", o_rotary_chg,  e_chg);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold;
    logic [31:0] rnd;
    logic [3:0] bounce [8];

    initial begin
        // 1: reset, then nothing pulses after release
        #3 rst_n = 1'b0;
        tick(3);
        check("rst_level", o_key_level, 0);
        check("rst_rotary", o_rotary, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("post_rst_quiet",
                  {o_key_press, o_key_release, o_key_long, o_rotary_chg}, 0);
        end

        // 2: key0 press, 6 cycle latency
        i_key = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("t2_press", o_key_press, (k == 6) ? 2'b01 : 2'b00);
            check("t2_level", o_key_level, (k >= 6) ? 2'b01 : 2'b00);
        end
        i_key = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t2_release", o_key_release, (k == 6) ? 2'b01 : 2'b00);
        end
        tick(4);

        // 3: bounce low3/high1/low3/high1, then hold low
        bounce = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        for (int k = 0; k < 8; k++) begin
            i_key = {1'b1, bounce[k][0]};
            @(negedge clk);
            check("t3_bounce_press", o_key_press, 0);
        end
        i_key = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t3_press", o_key_press, (k == 6) ? 2'b01 : 2'b00);
        end
        i_key = 2'b11;
        tick(12);

        // 4: key1 long press, no repeat, then release
        i_key = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("t4_press", o_key_press, (k == 6) ? 2'b10 : 2'b00);
            check("t4_long", o_key_long, (k == 26) ? 2'b10 : 2'b00);
        end
        i_key = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t4_release", o_key_release, (k == 6) ? 2'b10 : 2'b00);
            check("t4_long_after", o_key_long, 0);
        end
        tick(4);

        // 5: rotary F -> B glitch (2 cycles) -> A
        i_rotary = 4'hB;
        tick(2);
        i_rotary = 4'hA;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("t5_chg", o_rotary_chg, (k == 6) ? 1 : 0);
            check("t5_rotary", o_rotary, (k >= 6) ? 4'h5 : 4'h0);
        end

        // 6: reset mid-cycle while key0 is pressed
        i_key = 2'b10;
        tick(10);
        check("t6_pre_level", o_key_level, 2'b01);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_out",
              {o_key_level, o_key_press, o_key_release, o_key_long, o_rotary, o_rotary_chg}, 0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("t6_press", o_key_press, (k == 6) ? 2'b01 : 2'b00);
            check("t6_no_release", o_key_release, 0);
        end
        i_key = 2'b11;
        tick(10);

        // Random phase: model comparison every cycle
        for (int n = 0; n < 200; n++) begin
            rnd = $urandom;
            if (rnd[3:2] != 2'b00) i_key = rnd[1:0];
            if (rnd[6:4] == 3'b000) i_rotary = rnd[11:8];
            if (rnd[14:12] == 3'b000) hold = $urandom_range(20, 40);
            else hold = $urandom_range(1, 7);
            tick(hold);
        end
        i_key = 2'b11;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
